// File: rtl/math_pkg.sv
// Shared widths and saturation bounds for the signed Q1.8 gain multiplier.
package math_pkg;
    localparam int A_W    = 9;
    localparam int B_W    = 12;
    localparam int P_W    = 12;
    localparam int FRAC   = 8;
    localparam int PROD_W = A_W + B_W;

    // Bounds held at full product width so the shifted value compares without truncation.
    localparam logic signed [PROD_W-1:0] S_MAX = PROD_W'(2 ** (P_W - 1) - 1);
    localparam logic signed [PROD_W-1:0] S_MIN = ~S_MAX;

    localparam logic signed [P_W-1:0] P_MAX = S_MAX[P_W-1:0];
    localparam logic signed [P_W-1:0] P_MIN = S_MIN[P_W-1:0];
endpackage

// File: rtl/math_sat.sv
// Combinational floor-shift of the full product by FRAC followed by clamp to P_W bits.
module math_sat
    import math_pkg::*;
(
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [P_W-1:0]    sat
);
    logic signed [PROD_W-1:0] shifted;

    always_comb begin
        shifted = prod >>> FRAC;
        if (shifted > S_MAX) begin
            sat = P_MAX;
        end else if (shifted < S_MIN) begin
            sat = P_MIN;
        end else begin
            sat = shifted[P_W-1:0];
        end
    end
endmodule

// File: rtl/math.sv
// Two-stage signed gain multiplier: exact product register, then shift/saturate into p.
module math
    import math_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic                  out_valid,
    output logic signed [P_W-1:0] p
);
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod_next;
    logic signed [PROD_W-1:0] prod_reg;
    logic                     valid1_reg;
    logic signed [P_W-1:0]    sat_next;
    logic signed [P_W-1:0]    p_reg;
    logic                     out_valid_reg;

    // Full-width operands make the product exact at PROD_W bits.
    assign a_ext     = $signed({{B_W{a[A_W-1]}}, a});
    assign b_ext     = $signed({{A_W{b[B_W-1]}}, b});
    assign prod_next = a_ext * b_ext;

    math_sat u_sat (
        .prod (prod_reg),
        .sat  (sat_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_reg      <= '0;
            valid1_reg    <= 1'b0;
            p_reg         <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            valid1_reg    <= in_valid;
            out_valid_reg <= valid1_reg;
            // Idle cycles leave both data registers untouched so p keeps the last result.
            if (in_valid) begin
                prod_reg <= prod_next;
            end
            if (valid1_reg) begin
                p_reg <= sat_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign p         = p_reg;
endmodule

// File: tb/tb_math.sv
// Scoreboard bench for math: directed operand pairs, expected results queued with due cycle.
module tb_math;
    import math_pkg::*;

    typedef struct {
        int exp_p;
        int due;
    } exp_t;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic signed [A_W-1:0] a;
    logic signed [B_W-1:0] b;
    logic                  out_valid;
    logic signed [P_W-1:0] p;

    exp_t q[$];
    exp_t e;
    int   cyc;
    int   last_p;
    int   total;
    int   passed;

    math dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .p         (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            check("reset_p", int'(p), 0);
            check("reset_out_valid", int'(out_valid), 0);
            q.delete();
            last_p = 0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("p", int'(p), e.exp_p);
                check("latency", cyc, e.due);
                $display("out cycle %0d: p=%0d expected %0d", cyc, p, e.exp_p);
                last_p = e.exp_p;
            end
        end else begin
            check("hold_p", int'(p), last_p);
        end
    end

    task automatic send(input int av, input int bv, input int exp);
        @(negedge clk);
        in_valid = 1'b1;
        a        = A_W'(av);
        b        = B_W'(bv);
        q.push_back('{exp_p: exp, due: cyc + 2});
        $display("in  cycle %0d: a=%0d b=%0d expect p=%0d", cyc, av, bv, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            a        = '0;
            b        = '0;
        end
    endtask

    initial begin
        total    = 0;
        passed   = 0;
        last_p   = 0;
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(3);

        send(255, -2047, -2040);  idle(3);
        send(255,  2047,  2039);  idle(3);
        send(128,   100,    50);  idle(3);
        send(0,   -2048,     0);  idle(3);
        send(-256, -2048,  2047); idle(3);
        send(-256,  1000, -1000); idle(3);

        send(100, -300, -118);
        send(-1,    -1,    0);
        send(-1,     1,   -1);
        send(200, 2000, 1562);
        idle(4);

        // Reset with one result emerging and one still in stage 1.
        send(255, 2047, 2039);
        send(128, 100, 50);
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(3);

        send(-256, 1000, -1000);
        idle(4);

        check("drain_queue_empty", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
